hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Controls the 5-stage pipeline's operand-forwarding muxes and inserts load-use stalls.
- Keeps its own shadow pipeline of destination info for the EX, MEM and WB stages.
- For the instruction in ID it computes the select codes: 00 = register file, 01 = ALU_Result (EX/MEM), 10 = data-memory read data (MEM/WB).
- Registers those codes so they line up with the instruction when it reaches EX. Stalls IF/ID and bubbles ID/EX on a load-use hazard.

Parameters:
REG_AW, 5, register-address width
CNT_W, 32, perf-counter width (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  reset; synchronous, active-high, sampled on rising clk
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_AW  ID source register 1
id_rt  in  REG_AW  ID source register 2
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_reg_write  in  1  ID instruction writes a register
id_mem_read  in  1  ID instruction is a load
id_dst  in  REG_AW  ID destination register (rd or rt, already selected)
forward_a  out  2  select for operand A mux, valid for the instruction in EX
forward_b  out  2  select for operand B mux, valid for the instruction in EX
stall_if_id  out  1  hold PC and IF/ID register
bubble_id_ex  out  1  load a NOP into ID/EX
stall_count  out  CNT_W  cumulative stall cycles (optional feature only)
fwd_count  out  CNT_W  cumulative non-zero forward selects (optional feature only)

Behaviour:
- Shadow stages ex_q, mem_q and wb_q each hold {v, rw, mr, dst}. They shift every cycle: ID→EX→MEM→WB.
- When a bubble is inserted, ex_q loads all zeros. mem_q and wb_q still advance.
- Hazard is combinational: haz = id_valid & ex_q.v & ex_q.mr & ex_q.dst≠0 & ((id_use_rs & id_rs==ex_q.dst) | (id_use_rt & id_rt==ex_q.dst)).
- stall_if_id = bubble_id_ex = haz, in the same cycle. Both are combinational outputs.
- Forward select for source s (rs → forward_a, rt → forward_b):
  - Evaluated for the ID instruction against ex_q and mem_q.
  - If the source is used, s≠0, ex_q.v & ex_q.rw & ex_q.dst==s & !ex_q.mr: next select = 01. Next cycle that producer is in MEM and its ALU_Result is valid.
  - Else if the source is used, s≠0, mem_q.v & mem_q.rw & mem_q.dst==s: next select = 10.
  - Else: next select = 00.
  - EX match has priority over MEM match (youngest producer wins).
- A load in ex_q that matches is a hazard, never a forward. After the one-cycle stall the load sits in mem_q and the 10 path applies.
- forward_a and forward_b are registered (latency 1). When haz=1 they load 00, because the bubble is in EX.
- Register 0 is never forwarded and never stalls.
- Back-to-back loads with a dependent third instruction produce exactly one stall cycle per load-use pair. There are no cumulative stalls.
- Reset: all shadow stages cleared (v=0), forward_a = forward_b = 00, and the counters cleared. stall_if_id and bubble_id_ex read 0 because all v=0.
- Reset mid-stall: state clears on the next edge and the stall drops.
- id_valid=0 produces no stall and sets both next selects to 00.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined:
  - stall_count increments on each cycle with haz=1.
  - fwd_count increments by (next forward_a≠00) + (next forward_b≠00) each non-stall cycle.
  - Both counters saturate at all-ones and clear on reset.
- When undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - REG_AW.
  - FWD_REG=2'b00, FWD_ALU=2'b01, FWD_MEM=2'b10.
  - The stage-info struct typedef {v, rw, mr, dst}.
- One sub-module, fwd_select: purely combinational. It takes a source register, its use bit, ex_q and mem_q, and returns the 2-bit select. It is instantiated twice, for rs and rt.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 → next cycle forward_a=01, forward_b=00, no stall.
- add $3,.. ; nop ; or $6,$0,$3 → forward_b=10 when or is in EX.
- lw $3,0($1) then add $4,$3,$3 → stall_if_id=bubble_id_ex=1 for exactly 1 cycle. Then forward_a=forward_b=10. With HAZ_PERF_CNT_EN, stall_count=1.
- add $3,.. ; add $3,.. ; add $5,$3,$3 → forward_a=forward_b=01 (EX priority over MEM).
- Writes to $0 followed by a reader of $0 → selects 00 and no stall. lw $0 followed by a use → no stall.
- Assert reset during a load-use stall → next cycle stall=0 and forwards=00. Counters read 0 when the feature is enabled.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared register width, forward select codes and shadow stage record
package mips_pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Destination info carried down the shadow pipeline
  typedef struct packed {
    logic              v;
    logic              rw;
    logic              mr;
    logic [REG_AW-1:0] dst;
  } stage_info_t;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// rtl/hazard_forward_ctrl_fwd_select.sv - forward select for one source operand
module fwd_select
  import mips_pipe_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  stage_info_t       ex_q,
  input  stage_info_t       mem_q,
  output logic [1:0]        sel
);

  logic live_src;
  logic ex_hit;
  logic mem_hit;

  // Register 0 is hardwired, so it never needs a bypass
  assign live_src = use_src && (src != '0);

  // A load in EX has no ALU result worth bypassing; the stall logic handles it
  assign ex_hit  = live_src && ex_q.v && ex_q.rw && !ex_q.mr && (ex_q.dst == src);
  assign mem_hit = live_src && mem_q.v && mem_q.rw && (mem_q.dst == src);

  // Youngest producer wins: EX beats MEM
  always_comb begin
    sel = FWD_REG;
    if (ex_hit) begin
      sel = FWD_ALU;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - forwarding select and load-use stall control; HAZ_PERF_CNT_EN adds perf counters
module hazard_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] id_dst,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  fwd_count
);

  import mips_pipe_pkg::*;

  stage_info_t ex_q;
  stage_info_t mem_q;
  stage_info_t wb_q;
  stage_info_t id_info;

  logic       haz;
  logic       rs_hit;
  logic       rt_hit;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  assign id_info = '{v: id_valid, rw: id_reg_write, mr: id_mem_read, dst: id_dst};

  // Load-use: the load in EX has not produced its data yet
  assign rs_hit = id_use_rs && (id_rs == ex_q.dst);
  assign rt_hit = id_use_rt && (id_rt == ex_q.dst);
  assign haz    = id_valid && ex_q.v && ex_q.mr && (ex_q.dst != '0) && (rs_hit || rt_hit);

  assign stall_if_id  = haz;
  assign bubble_id_ex = haz;

  // An empty ID slot must not select a bypass
  fwd_select u_fwd_a (
    .src     (id_rs),
    .use_src (id_use_rs && id_valid),
    .ex_q    (ex_q),
    .mem_q   (mem_q),
    .sel     (sel_a)
  );

  fwd_select u_fwd_b (
    .src     (id_rt),
    .use_src (id_use_rt && id_valid),
    .ex_q    (ex_q),
    .mem_q   (mem_q),
    .sel     (sel_b)
  );

  // Shadow pipeline advance; a bubble enters EX with register-file selects
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      forward_a <= FWD_REG;
      forward_b <= FWD_REG;
    end else begin
      ex_q      <= haz ? '0 : id_info;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      forward_a <= haz ? FWD_REG : sel_a;
      forward_b <= haz ? FWD_REG : sel_b;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [1:0]     fwd_inc;
  logic [CNT_W:0] fwd_sum;

  assign fwd_inc = {1'b0, (sel_a != FWD_REG)} + {1'b0, (sel_b != FWD_REG)};
  assign fwd_sum = {1'b0, fwd_count} + {{(CNT_W-1){1'b0}}, fwd_inc};

  // Saturating stall and forward counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else if (haz) begin
      if (stall_count != '1) begin
        stall_count <= stall_count + 1'b1;
      end
    end else begin
      fwd_count <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
    end
  end
`else
  assign stall_count = '0;
  assign fwd_count   = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed vector bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_reg_write;
  logic        id_mem_read;
  logic [4:0]  id_dst;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        stall_if_id;
  logic        bubble_id_ex;
  logic [31:0] stall_count;
  logic [31:0] fwd_count;

  int vectors     = 0;
  int miscompares = 0;

  hazard_forward_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_dst       (id_dst),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall_if_id  (stall_if_id),
    .bubble_id_ex (bubble_id_ex),
    .stall_count  (stall_count),
    .fwd_count    (fwd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one ID-stage instruction just after the falling edge
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rw,
                       input logic mr, input logic [4:0] dst);
    @(negedge clk);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_use_rs    = urs;
    id_use_rt    = urt;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_dst       = dst;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, "_stall"}, {31'd0, stall_if_id}, {31'd0, exp});
    chk({tag, "_bubble"}, {31'd0, bubble_id_ex}, {31'd0, exp});
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
    chk({tag, "_fwd_a"}, {30'd0, forward_a}, {30'd0, exp_a});
    chk({tag, "_fwd_b"}, {30'd0, forward_b}, {30'd0, exp_b});
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_dst = '0;
    repeat (2) @(posedge clk);
    nop();
    chk_stall("reset", 1'b0);
    chk_fwd("reset", 2'b00, 2'b00);
    chk("reset_stall_count", stall_count, 32'd0);
    chk("reset_fwd_count", fwd_count, 32'd0);
    reset = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    chk_stall("add", 1'b0);
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
    chk_stall("sub", 1'b0);
    nop();
    chk_fwd("ex_fwd", 2'b01, 2'b00);

    // add $3 ; nop ; or $6,$0,$3
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    nop();
    drive(1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
    chk_stall("or", 1'b0);
    nop();
    chk_fwd("mem_fwd", 2'b00, 2'b10);

    // lw $3,0($1) ; add $4,$3,$3
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
    chk_stall("lw", 1'b0);
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
    chk_stall("lu_first", 1'b1);
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
    chk_stall("lu_second", 1'b0);
    chk_fwd("lu_bubble", 2'b00, 2'b00);
`ifdef HAZ_PERF_CNT_EN
    chk("lu_stall_count", stall_count, 32'd1);
`endif
    nop();
    chk_fwd("lu_fwd", 2'b10, 2'b10);
`ifdef HAZ_PERF_CNT_EN
    chk("fwd_count", fwd_count, 32'd4);
`endif

    // add $3 ; add $3 ; add $5,$3,$3
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
    nop();
    chk_fwd("ex_priority", 2'b01, 2'b01);

    // add $0 ; or $7,$0,$0
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
    chk_stall("r0_write", 1'b0);
    nop();
    chk_fwd("r0_write", 2'b00, 2'b00);

    // lw $0 ; add $8,$0,$0
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
    chk_stall("r0_load", 1'b0);
    nop();
    chk_fwd("r0_load", 2'b00, 2'b00);

    // lw $9 ; invalid slot naming $9
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
    drive(1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1);
    chk_stall("invalid_id", 1'b0);
    nop();
    chk_fwd("invalid_id", 2'b00, 2'b00);

    // lw $10 ; add $11,$10,$0 then reset during the stall
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10);
    drive(1'b1, 5'd10, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11);
    chk_stall("pre_reset", 1'b1);
    reset = 1'b1;
    drive(1'b1, 5'd10, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11);
    chk_stall("mid_reset", 1'b0);
    chk_fwd("mid_reset", 2'b00, 2'b00);
    chk("mid_reset_stall_count", stall_count, 32'd0);
    chk("mid_reset_fwd_count", fwd_count, 32'd0);
    reset = 1'b0;
    nop();
    chk_fwd("post_reset", 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
